// File: rtl/rf_blackwidow_dcache_rway.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rf_blackwidow_dcache_rway: 4-way tag/valid store, lookup, fill, invalidate. |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module rf_blackwidow_dcache_rway #(
  parameter int AWID  = 32,
  parameter int LINES = 64,
  parameter int LOBIT = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req,
  input  logic [AWID-1:0] adr,
  output logic            rvalid,
  output logic            hit,
  output logic [1:0]      rway,
  input  logic            wr,
  input  logic [AWID-1:0] wadr,
  input  logic [1:0]      wway,
  input  logic            inv_line,
  input  logic [AWID-1:0] iadr,
  input  logic            inv_all,
  output logic            busy,
  output logic [1:0]      lfsr
);

  localparam int C_IW = $clog2(LINES);
  localparam int C_TW = AWID - LOBIT - C_IW;

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_SWEEP = 1'b1} state_t;

  state_t            r_state, w_state_nxt;
  logic [C_IW-1:0]   r_idx, w_idx_nxt;
  logic [3:0]        r_valid [LINES];
  logic [C_TW-1:0]   r_tag   [LINES][4];
  logic              r_rvalid, r_hit;
  logic [1:0]        r_rway;
  logic [15:0]       r_lfsr;

  logic              w_busy, w_rd_acc, w_wr_acc, w_inv_acc;
  logic [C_IW-1:0]   w_ridx, w_widx, w_iidx;
  logic [C_TW-1:0]   w_rtag, w_wtag, w_itag;
  logic [3:0]        w_fwd, w_match, w_imatch;
  logic [1:0]        w_way;

  assign w_busy    = (r_state == S_SWEEP);
  assign w_rd_acc  = req & ~w_busy;
  assign w_wr_acc  = wr & ~w_busy;
  assign w_inv_acc = inv_line & ~w_busy;

  assign w_ridx = adr[LOBIT +: C_IW];
  assign w_widx = wadr[LOBIT +: C_IW];
  assign w_iidx = iadr[LOBIT +: C_IW];
  assign w_rtag = adr[AWID-1 -: C_TW];
  assign w_wtag = wadr[AWID-1 -: C_TW];
  assign w_itag = iadr[AWID-1 -: C_TW];

  // A same-cycle fill overrides the stored way so the lookup sees it.
  for (genvar gv = 0; gv < 4; gv++) begin : g_way
    assign w_fwd[gv]    = w_wr_acc && (w_widx == w_ridx) && (wway == 2'(gv));
    assign w_match[gv]  = w_fwd[gv] ? (w_wtag == w_rtag)
                                    : (r_valid[w_ridx][gv] && (r_tag[w_ridx][gv] == w_rtag));
    assign w_imatch[gv] = r_valid[w_iidx][gv] && (r_tag[w_iidx][gv] == w_itag);
  end

  always_comb begin
    w_way = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (w_match[i]) w_way = 2'(i);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    case (r_state)
      S_IDLE: begin
        if (inv_all) begin
          w_state_nxt = S_SWEEP;
          w_idx_nxt   = '0;
        end
      end
      S_SWEEP: begin
        if (inv_all) begin
          w_idx_nxt = '0;
        end else if (r_idx == C_IW'(LINES - 1)) begin
          w_state_nxt = S_IDLE;
          w_idx_nxt   = '0;
        end else begin
          w_idx_nxt = r_idx + 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_SWEEP;
        w_idx_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_SWEEP;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // Invalidate is applied first; the later fill assignment wins on its bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < LINES; s++) r_valid[s] <= 4'b0000;
    end else if (w_busy) begin
      r_valid[r_idx] <= 4'b0000;
    end else begin
      if (w_inv_acc) r_valid[w_iidx] <= r_valid[w_iidx] & ~w_imatch;
      if (w_wr_acc)  r_valid[w_widx][wway] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_acc) r_tag[w_widx][wway] <= w_wtag;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rvalid <= 1'b0;
      r_hit    <= 1'b0;
      r_rway   <= 2'd0;
      r_lfsr   <= 16'hACE1;
    end else begin
      r_rvalid <= w_rd_acc;
      r_hit    <= w_rd_acc & (|w_match);
      r_rway   <= w_rd_acc ? w_way : 2'd0;
      if (w_wr_acc) r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    end
  end

  assign rvalid = r_rvalid;
  assign hit    = r_hit;
  assign rway   = r_rway;
  assign busy   = w_busy;
  assign lfsr   = r_lfsr[1:0];

endmodule
`default_nettype wire

// File: tb/tb_rf_blackwidow_dcache_rway.sv
`default_nettype none
// Scoreboard bench for rf_blackwidow_dcache_rway: directed lookups, fills,
// invalidates and sweeps with hand-computed expectations.
module tb_rf_blackwidow_dcache_rway;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic [31:0] adr = '0;
  logic        rvalid, hit;
  logic [1:0]  rway;
  logic        wr = 1'b0;
  logic [31:0] wadr = '0;
  logic [1:0]  wway = '0;
  logic        inv_line = 1'b0;
  logic [31:0] iadr = '0;
  logic        inv_all = 1'b0;
  logic        busy;
  logic [1:0]  lfsr;

  rf_blackwidow_dcache_rway #(.AWID(32), .LINES(64), .LOBIT(5)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .adr(adr),
    .rvalid(rvalid), .hit(hit), .rway(rway),
    .wr(wr), .wadr(wadr), .wway(wway),
    .inv_line(inv_line), .iadr(iadr), .inv_all(inv_all),
    .busy(busy), .lfsr(lfsr)
  );

  always #5 clk = ~clk;

  int          n_pass = 0;
  int          n_total = 0;
  logic [2:0]  exp_q[$];
  string       name_q[$];
  logic [15:0] m_lfsr = 16'hACE1;
  int          n_fill = 0;
  logic [1:0]  hand_lfsr [4] = '{2'b11, 2'b11, 2'b11, 2'b10};

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    else n_pass++;
  endtask

  // One cycle of stimulus; inputs are launched at a negedge.
  task automatic op(input string nm,
                    input bit do_req, input logic [31:0] a, input bit eh, input logic [1:0] ew,
                    input bit do_wr, input logic [31:0] wa, input logic [1:0] ww,
                    input bit do_inv, input logic [31:0] ia);
    req = do_req; adr = a;
    wr = do_wr; wadr = wa; wway = ww;
    inv_line = do_inv; iadr = ia;
    if (do_req) begin
      exp_q.push_back({eh, ew});
      name_q.push_back(nm);
    end
    @(negedge clk);
    req = 1'b0; wr = 1'b0; inv_line = 1'b0;
    if (do_wr) begin
      m_lfsr = lfsr_next(m_lfsr);
      chk({nm, "_lfsr"}, 32'(lfsr), 32'(m_lfsr[1:0]));
      if (n_fill < 4) chk({nm, "_lfsr_hand"}, 32'(lfsr), 32'(hand_lfsr[n_fill]));
      n_fill++;
    end
  endtask

  task automatic look(input string nm, input logic [31:0] a, input bit eh, input logic [1:0] ew);
    op(nm, 1'b1, a, eh, ew, 1'b0, '0, 2'd0, 1'b0, '0);
  endtask

  task automatic fill(input string nm, input logic [31:0] wa, input logic [1:0] ww);
    op(nm, 1'b0, '0, 1'b0, 2'd0, 1'b1, wa, ww, 1'b0, '0);
  endtask

  // Monitor: every presented result must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && rvalid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_rvalid: got hit=%0b rway=%0d with nothing expected", hit, rway);
      end else begin
        chk(name_q.pop_front(), {29'd0, hit, rway}, {29'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("reset_rvalid", 32'(rvalid), 32'd0);
    chk("reset_hit",    32'(hit),    32'd0);
    chk("reset_rway",   32'(rway),   32'd0);
    chk("reset_busy",   32'(busy),   32'd1);
    chk("reset_lfsr",   32'(lfsr),   32'd1);

    // Reset sweep with req held: lookups are dropped until busy drops.
    rst_n = 1'b1; req = 1'b1; adr = 32'h1000;
    n = 0;
    while (busy && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk("reset_busy_cycles", 32'(n), 32'd64);
    exp_q.push_back(3'b0_00);
    name_q.push_back("post_reset_lookup");
    chk("lfsr_before_wr", 32'(lfsr), 32'd1);
    @(negedge clk);
    req = 1'b0;

    // Fill then hit / miss on same set.
    fill("fill_12340_w2", 32'h0001_2340, 2'd2);
    look("hit_same_line", 32'h0001_235C, 1'b1, 2'd2);
    look("miss_other_tag", 32'h0002_2340, 1'b0, 2'd0);

    // Forwarding and lowest-way priority.
    op("fwd_w3", 1'b1, 32'h4000, 1'b1, 2'd3, 1'b1, 32'h4000, 2'd3, 1'b0, '0);
    fill("fill_4000_w1", 32'h4000, 2'd1);
    look("prio_w1", 32'h4000, 1'b1, 2'd1);

    // inv_line vs wr in set 5, tag 3 (address 0x18A0).
    fill("fill_18a0_w0", 32'h18A0, 2'd0);
    fill("fill_18a0_w1", 32'h18A0, 2'd1);
    op("inv_and_wr", 1'b0, '0, 1'b0, 2'd0, 1'b1, 32'h18A0, 2'd1, 1'b1, 32'h18A0);
    look("after_inv_wr", 32'h18A0, 1'b1, 2'd1);
    op("inv_with_req", 1'b1, 32'h18A0, 1'b1, 2'd1, 1'b0, '0, 2'd0, 1'b1, 32'h18A0);
    look("after_inv_line", 32'h18A0, 1'b0, 2'd0);

    // Sweep, restarted 10 cycles in; a wr and req during busy are dropped.
    inv_all = 1'b1;
    @(negedge clk);
    inv_all = 1'b0;
    n = 0;
    while (busy && n < 300) begin
      n++;
      inv_all = (n == 10);
      wr = (n == 3); wadr = 32'h0001_2340; wway = 2'd0;
      req = (n == 4); adr = 32'h0001_2340;
      @(negedge clk);
    end
    inv_all = 1'b0; wr = 1'b0; req = 1'b0;
    chk("sweep_busy_cycles", 32'(n), 32'd74);
    chk("lfsr_no_adv_busy", 32'(lfsr), 32'(m_lfsr[1:0]));
    look("swept_12340", 32'h0001_235C, 1'b0, 2'd0);
    look("swept_4000", 32'h4000, 1'b0, 2'd0);
    look("swept_18a0", 32'h18A0, 1'b0, 2'd0);
    fill("fill_after_sweep", 32'h0003_0040, 2'd2);
    look("hit_after_sweep", 32'h0003_0040, 1'b1, 2'd2);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
